piso_serial_tx: RTL

//   Parallel-in/serial-out framed transmitter: the sending end of the lab's serial link.

---
 rtl/piso_tx_pkg.sv | 20 ++
 rtl/bit_tick_gen.sv | 33 +++
 rtl/piso_serial_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the framed PISO serial transmitter: FSM encoding and
// the counter-width helper.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Bits needed to count 0..value-1, never less than one so a counter always exists.
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: counts clocks within one line bit and pulses tick on the
// last clock of the period. restart forces the count back to zero.
module bit_tick_gen
  import piso_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int             TW   = clog2_min1(CLKS_PER_BIT);
  localparam logic [TW-1:0]  LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, DATA_W bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks; idle line high.
module piso_serial_tx
  import piso_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              async_reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int            BW       = clog2_min1(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic              ser_next;
  logic              done_next;
  logic              tick;
  logic              restart;
  logic              accept;

  assign load_ready = (state == TX_IDLE);
  assign busy       = ~load_ready;
  assign accept     = load_valid && load_ready;
  // Timer is held clear while idle and restarts on every state change.
  assign restart    = (state_next != state) || (state == TX_IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (Clk),
    .rst    (async_reset),
    .restart(restart),
    .tick   (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
    ser_next     = 1'b1;

    case (state)
      TX_IDLE: begin
        if (accept) begin
          state_next = TX_START;
          shreg_next = data_in;
        end
      end
      TX_START: begin
        if (tick) state_next = TX_DATA;
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_next = TX_STOP;
          end else begin
            shreg_next   = shreg >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          state_next = TX_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = TX_IDLE;
    endcase

    if (state_next != state) bit_cnt_next = '0;

    // ser_out is registered, so it is driven from the state being entered.
    case (state_next)
      TX_START: ser_next = 1'b0;
      TX_DATA:  ser_next = shreg_next[0];
      default:  ser_next = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge async_reset) begin
    if (async_reset) begin
      state   <= TX_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ser_out <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      ser_out <= ser_next;
      done    <= done_next;
    end
  end

endmodule
